// File: rtl/way_fill_decoder_pkg.sv
// Shared cache package: FSM encoding and default geometry for the
// set-associative cache line-fill path.
package way_fill_decoder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CACHE_WAYS   = 8;
  localparam int CACHE_IDX_W  = 3;
  localparam int CACHE_BEATS  = 4;
  localparam int CACHE_DATA_W = 32;

endpackage

// File: rtl/way_fill_decoder_way_dec.sv
// Encoded way index to one-hot write-enable; inverse of the cache's
// way priority encoder.
module way_dec #(
  parameter int WAYS  = 8,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WAYS-1:0]  onehot
);

  for (genvar k = 0; k < WAYS; k++) begin : g_way
    assign onehot[k] = en & (idx == IDX_W'(k));
  end

endmodule

// File: rtl/way_fill_decoder.sv
// Line-fill sequencer: accepts a victim way, then steers BEATS data beats
// into that way's data array one registered write per accepted beat.
module way_fill_decoder
  import way_fill_decoder_pkg::*;
#(
  parameter int WAYS   = CACHE_WAYS,
  parameter int IDX_W  = CACHE_IDX_W,
  parameter int BEATS  = CACHE_BEATS,
  parameter int DATA_W = CACHE_DATA_W,
  localparam int CNT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req,
  input  logic [IDX_W-1:0]  fill_way,
  output logic              fill_ack,
  input  logic              beat_valid,
  input  logic [DATA_W-1:0] beat_data,
  output logic [WAYS-1:0]   way_we,
  output logic [CNT_W-1:0]  word_sel,
  output logic [DATA_W-1:0] wdata,
  output logic              fill_busy,
  output logic              fill_done
);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] way_q;
  logic             beat_acc;
  logic             last_beat;
  logic [WAYS-1:0]  dec;

  // Gated by reset so no acceptance leaks out while reset is held.
  assign fill_ack  = ~reset & (state == ST_IDLE) & fill_req;
  assign beat_acc  = (state == ST_FILL) & beat_valid;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign fill_busy = (state != ST_IDLE);
  assign fill_done = (state == ST_DONE);

  way_dec #(.WAYS(WAYS), .IDX_W(IDX_W)) u_way_dec (
    .idx    (way_q),
    .en     (beat_acc),
    .onehot (dec)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fill_ack) state_nxt = ST_FILL;
      ST_FILL: if (beat_acc && last_beat) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      way_q <= '0;
    end else begin
      state <= state_nxt;
      if (fill_ack) begin
        cnt   <= '0;
        way_q <= fill_way;
      end else if (beat_acc) begin
        cnt <= cnt + CNT_W'(1);  // wraps to 0 on the last beat
      end
    end
  end

  // One-cycle write stage toward the data arrays.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      way_we   <= '0;
      word_sel <= '0;
      wdata    <= '0;
    end else begin
      way_we <= dec;
      if (beat_acc) begin
        word_sel <= cnt;
        wdata    <= beat_data;
      end
    end
  end

endmodule

// File: tb/tb_way_fill_decoder.sv
// Scoreboard bench for way_fill_decoder: directed fill scenarios plus random
// traffic against a beats-remaining reference model.
module tb_way_fill_decoder;

  localparam int WAYS   = 8;
  localparam int IDX_W  = 3;
  localparam int BEATS  = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              ack;
    logic              busy;
    logic              done;
    logic [WAYS-1:0]   we;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              fill_req;
  logic [IDX_W-1:0]  fill_way;
  logic              fill_ack;
  logic              beat_valid;
  logic [DATA_W-1:0] beat_data;
  logic [WAYS-1:0]   way_we;
  logic [1:0]        word_sel;
  logic [DATA_W-1:0] wdata;
  logic              fill_busy;
  logic              fill_done;

  way_fill_decoder #(.WAYS(WAYS), .IDX_W(IDX_W), .BEATS(BEATS), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .fill_req(fill_req), .fill_way(fill_way),
    .fill_ack(fill_ack), .beat_valid(beat_valid), .beat_data(beat_data),
    .way_we(way_we), .word_sel(word_sel), .wdata(wdata),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: a fill is "beats still owed"; done is the cycle after the last one.
  int                beats_left = 0;
  bit                done_now   = 0;
  int                mway       = 0;
  logic [WAYS-1:0]   p_we       = '0;
  logic [1:0]        p_sel      = '0;
  logic [DATA_W-1:0] p_data     = '0;

  task automatic step(input logic r, input logic req, input int w,
                      input logic bv, input logic [DATA_W-1:0] d);
    exp_t e;
    bit   nd;
    reset = r; fill_req = req; fill_way = IDX_W'(w); beat_valid = bv; beat_data = d;
    e = '0;
    if (!r) begin
      e.busy = (beats_left > 0) || done_now;
      e.done = done_now;
      e.ack  = req && (beats_left == 0) && !done_now;
      e.we   = p_we;
      e.sel  = p_sel;
      e.data = p_data;
    end
    exp_q.push_back(e);
    if (r) begin
      beats_left = 0; done_now = 0; mway = 0; p_we = '0;
    end else begin
      nd   = 0;
      p_we = '0;
      if (beats_left > 0 && bv) begin
        p_we   = WAYS'(1) << mway;
        p_sel  = 2'(BEATS - beats_left);
        p_data = d;
        beats_left--;
        if (beats_left == 0) nd = 1;
      end
      done_now = nd;
      if (e.ack) begin
        mway       = w;
        beats_left = BEATS;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (fill_ack !== e.ack || fill_busy !== e.busy || fill_done !== e.done ||
            way_we !== e.we || (e.we != '0 && (word_sel !== e.sel || wdata !== e.data))) begin
          n_bad++;
          $display("FAIL outputs cyc%0d: got ack=%b busy=%b done=%b we=%h sel=%0d data=%h, need ack=%b busy=%b done=%b we=%h sel=%0d data=%h",
                   cyc, fill_ack, fill_busy, fill_done, way_we, word_sel, wdata,
                   e.ack, e.busy, e.done, e.we, e.sel, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1; fill_req = 0; fill_way = '0; beat_valid = 0; beat_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0);
    idle(2);

    // way 3, four back-to-back beats
    step(0, 1, 3, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hA0 + i);
    idle(3);

    // way 7, gapped beats
    step(0, 1, 7, 0, '0);
    begin
      logic [6:0] pat;
      pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
      for (int i = 0; i < 7; i++) step(0, 0, 0, pat[i], 32'hB0 + i);
    end
    idle(3);

    // way 5 fill with a competing way-1 request held throughout
    step(0, 1, 5, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 32'hC0 + i);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hC8 + i);
    idle(3);

    // reset mid-fill of way 2, then a clean way-0 fill
    step(0, 1, 2, 0, '0);
    step(0, 0, 0, 1, 32'hD0);
    step(0, 0, 0, 1, 32'hD1);
    step(1, 0, 0, 1, 32'hD2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'hD3 + i);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hE0 + i);
    idle(3);

    // beats in idle are dropped
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'hF0 + i);
    step(0, 1, 6, 1, 32'hF3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hF4 + i);
    idle(3);

    // every way in sequence
    for (int w = 0; w < WAYS; w++) begin
      step(0, 1, w, 0, '0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, {w[15:0], 16'(i)});
      idle(2);
    end

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, WAYS - 1)), $urandom_range(0, 2) != 0, $urandom);
    idle(4);

    #10;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/way_fill_decoder.md
WAY_FILL_DECODER -- requirements
Module: way_fill_decoder

Interface
REQ-001 Parameter WAYS, default 8, SHALL be the number of cache ways, one write-enable each.
REQ-002 Parameter IDX_W, default 3, SHALL be the way-index width, with 2**IDX_W == WAYS.
REQ-003 Parameter BEATS, default 4, SHALL be the number of data beats per line fill, a power of two and at least 2.
REQ-004 Parameter DATA_W, default 32, SHALL be the beat data width.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-007 Port fill_req, input, 1, SHALL request a line fill into way fill_way.
REQ-008 Port fill_way, input, IDX_W, SHALL be the encoded victim-way index, sampled only when a request is accepted.
REQ-009 Port fill_ack, output, 1, SHALL be a one-cycle pulse marking acceptance of fill_req.
REQ-010 Port beat_valid, input, 1, SHALL mark beat_data valid in the current cycle.
REQ-011 Port beat_data, input, DATA_W, SHALL be the fill data beat from memory.
REQ-012 Port way_we, output, WAYS, SHALL be the one-hot way write-enable into the data arrays.
REQ-013 Port word_sel, output, log2(BEATS), SHALL be the word offset within the line for the current write.
REQ-014 Port wdata, output, DATA_W, SHALL be the registered copy of beat_data for the current write.
REQ-015 Port fill_busy, output, 1, SHALL be high from the cycle after acceptance until the cycle after the last beat is written.
REQ-016 Port fill_done, output, 1, SHALL be a one-cycle pulse in the cycle after the last beat write.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, FILL and DONE.
REQ-018 In IDLE with fill_req=1, the block SHALL latch fill_way, pulse fill_ack in the same cycle (combinational from IDLE and fill_req), clear the beat counter and go to FILL.
REQ-019 fill_req SHALL be ignored in FILL and DONE, with no fill_ack and no change to the latched way.
REQ-020 In FILL, each cycle with beat_valid=1 SHALL produce, one cycle later, way_we equal to the one-hot decode of the latched way (bit k set iff way==k), word_sel equal to the counter value before increment, and wdata equal to beat_data.
REQ-021 way_we SHALL be all-zero in every cycle not required by REQ-020; it SHALL never have more than one bit set.
REQ-022 The beat counter SHALL be log2(BEATS) bits wide and increment by 1 per accepted beat; beat_valid=0 cycles SHALL stall it without a write.
REQ-023 On the beat where the counter equals BEATS-1, the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-024 In DONE, fill_done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-025 fill_busy SHALL be 1 in FILL and DONE and 0 in IDLE.
REQ-026 beat_valid received in IDLE or DONE SHALL be dropped, with no write and no counter change.
REQ-027 A fill_req held high through DONE SHALL be accepted in the first IDLE cycle that follows, giving a minimum two-cycle gap between the last beat and the next fill_ack.

Reset
REQ-028 While reset is asserted, the FSM SHALL be IDLE, the counter and latched way SHALL be 0, and way_we, word_sel, wdata, fill_busy, fill_done and fill_ack SHALL be 0.
REQ-029 Reset asserted mid-fill SHALL abort the fill immediately, with no further way_we and no fill_done; after deassertion the block SHALL accept a new fill_req.

Structure
REQ-030 The FSM state encoding, BEATS and DATA_W defaults SHALL live in the shared cache package used by the set-associative cache.
REQ-031 The index-to-one-hot decode SHALL be a separate combinational sub-module, way_dec, the inverse mapping of the cache's way priority encoder.

Verification
REQ-032 Scenario: fill_req with fill_way=3, then four consecutive beats 0xA0..0xA3 -> way_we=0x08 on four cycles, word_sel 0,1,2,3, wdata matching; fill_done one cycle after the last write.
REQ-033 Scenario: fill_way=7 with beat_valid gapped (1,0,0,1,1,0,1) -> exactly four writes with way_we=0x80, word_sel 0..3 in order, and no write on gap cycles.
REQ-034 Scenario: a second fill_req with fill_way=1 during the way-5 fill -> no ack; all writes use way_we=0x20; held request acked two cycles after the last beat.
REQ-035 Scenario: reset pulsed after two beats of a way-2 fill -> way_we=0 thereafter, no fill_done, fill_busy=0; a new fill to way 0 completes with way_we=0x01.
REQ-036 Scenario: beat_valid asserted in IDLE -> way_we stays 0 and the counter stays 0, so the next fill starts at word_sel=0.
REQ-037 Scenario: every fill_way from 0 to 7 in sequence -> way_we is exactly one-hot (1<<way) on every write cycle.
